mem_stage: RTL and testbench
============================

# mem_stage

MEM stage of the 16-bit pipelined CPU, directly downstream of the EX/MEM pipeline register. It executes loads and stores against the external asynchronous SRAM and the UART through a multi-cycle bus FSM. While an access is in flight it stalls the upstream pipeline. It resolves branches and owns the MEM/WB pipeline register that feeds write-back.

## Interface
- RAM_WAIT, 2: cycles each RAM strobe (OE_n/WE_n) stays low; legal 1..15.
- CLK  in  1  pipeline clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- writeSpecRegIn  in  2  special-register write select, from EX/MEM.
- memtoRegIn  in  1  write-back selects memory data, from EX/MEM.
- regWriteIn  in  1  register-file write enable, from EX/MEM.
- memReadIn  in  2  read op: 00 none, 01 RAM, 10 UART data, 11 UART status.
- memWriteIn  in  2  write op: 00 none, 01 RAM, 10 UART data, 11 treated as none.
- branchIn  in  1  branch instruction flag, from EX/MEM.
- zerobitIn  in  1  ALU zero flag, from EX/MEM.
- PCIn  in  16  branch target, from EX/MEM.
- ALUResultIn  in  16  memory address, or pass-through result.
- dataIn  in  16  store data, from EX/MEM.
- registerToWriteIdIn  in  3  destination register, from EX/MEM.
- ramAddr  out  16  SRAM address.
- ramDataOut  out  16  SRAM write data.
- ramDataIn  in  16  SRAM read data.
- ramDataOE  out  1  enables the top-level tristate onto the SRAM bus.
- ramCE_n  out  1  SRAM chip enable, active low.
- ramOE_n  out  1  SRAM output enable, active low.
- ramWE_n  out  1  SRAM write enable, active low.
- uartRdn  out  1  UART read strobe, active low.
- uartWrn  out  1  UART write strobe, active low.
- uartDataReady  in  1  UART has a received byte.
- uartTbre  in  1  UART transmit buffer empty.
- uartTsre  in  1  UART transmit shift register empty.
- stall  out  1  holds EX/MEM and all earlier stages.
- branchTaken  out  1  combinational: branchIn & zerobitIn, only while state is IDLE.
- branchTarget  out  16  combinational: PCIn.
- writeSpecRegOut, memtoRegOut, regWriteOut  out  2/1/1  MEM/WB control.
- memDataOut, ALUResultOut  out  16/16  MEM/WB data.
- registerToWriteIdOut  out  3  MEM/WB destination register.

## Operation
- States: IDLE, RAM_RD, RAM_WR, UART_RD, UART_WR, DONE.
- IDLE transitions:
  - A memReadIn op of 01 or 10 goes to RAM_RD or UART_RD.
  - Otherwise a memWriteIn op of 01 or 10 goes to RAM_WR or UART_WR.
  - If both a read and a write are present, the read wins and the write is dropped.
  - Otherwise the state stays IDLE.
- UART status read (11) completes in IDLE with no stall. Data is {14'b0, uartDataReady, uartTbre&uartTsre}.
- RAM_RD:
  - ramCE_n and ramOE_n are low for RAM_WAIT cycles; ramAddr = ALUResultIn.
  - ramDataIn is latched on the last cycle's edge; the FSM then goes to DONE.
- RAM_WR:
  - ramCE_n is low for RAM_WAIT cycles and ramDataOE = 1.
  - ramWE_n is low for the RAM_WAIT cycles except the last, so address and data are held one cycle past WE rising. For RAM_WAIT = 1, WE_n pulses low for that one cycle.
  - The FSM then goes to DONE.
- UART_RD: waits with no timeout for uartDataReady = 1. It then drives uartRdn low for one cycle, latches {8'b0, ramDataIn[7:0]}, and goes to DONE.
- UART_WR: waits for uartTbre & uartTsre. It then drives uartWrn low for one cycle with the data on ramDataOut[7:0] and ramDataOE = 1, and goes to DONE.
- DONE: stall is low. The next edge loads MEM/WB with the result and returns to IDLE, which also advances EX/MEM.
- stall = (IDLE and an access starting) or (state not in {IDLE, DONE}); it is forced to 0 while RST is high.
- MEM/WB register:
  - Loads the inputs plus memDataOut on every edge where stall = 0.
  - Where stall = 1 it loads a bubble: regWriteOut = 0, memtoRegOut = 0, writeSpecRegOut = 00, other fields unchanged.

## Timing
- Reset values:
  - All MEM/WB outputs 0; state IDLE.
  - ramCE_n, ramOE_n, ramWE_n, uartRdn, uartWrn = 1.
  - ramDataOE = 0; ramAddr and ramDataOut = 0.
  - stall = 0.
- Reset asserted mid-access releases every strobe immediately (asynchronously). The in-flight access is abandoned and never retried.
- Latencies:
  - Non-memory instruction: 1 cycle, with results visible at MEM/WB after one edge.
  - RAM access: RAM_WAIT + 2 cycles (IDLE + RAM_WAIT + DONE), with stall high for RAM_WAIT + 1 of them.
  - UART access: 3 cycles + wait cycles.
- Strobes are registered outputs and glitch-free.
- ramAddr and ramDataOut are stable for the whole time CE_n is low.

## Structure
- Package cpu_pkg:
  - Memory op encodings MEM_NONE, MEM_RAM, MEM_UART, MEM_UART_STAT.
  - FSM state enum.
  - Widths DATA_W = 16, REG_ID_W = 3.
- Sub-module mem_access_fsm: owns the FSM, the wait counter, and all RAM/UART strobes.
- The top level holds the MEM/WB register, branch logic, and stall composition.

## Test plan
- ALU op (regWriteIn = 1, ALUResultIn = 16'h1234, memReadIn = memWriteIn = 00) -> stall stays 0; after one edge ALUResultOut = 16'h1234 and regWriteOut = 1.
- RAM read at 16'h4000 returning 16'hBEEF, RAM_WAIT = 2 -> stall high for 3 cycles; ramOE_n low for 2 cycles; memDataOut = 16'hBEEF on the 4th edge; no bubble has regWriteOut = 1.
- RAM write of 16'hA5A5 to 16'h8000 -> ramWE_n low for exactly RAM_WAIT−1 cycles inside CE_n low; ramDataOut = 16'hA5A5 throughout.
- UART read with uartDataReady rising 5 cycles late -> stall held through the wait; uartRdn low for exactly 1 cycle; memDataOut = {8'b0, byte}.
- UART status read with dataReady = 1, tbre = 1, tsre = 0 -> no stall; memDataOut = 16'h0002.
- RST pulsed during RAM_RD -> all strobes high and stall 0 at once; state IDLE; a read issued afterwards completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: widths, memory-op encodings and
// the MEM-stage bus FSM state type.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_ID_W = 3;

  localparam logic [1:0] MEM_NONE      = 2'b00;
  localparam logic [1:0] MEM_RAM       = 2'b01;
  localparam logic [1:0] MEM_UART      = 2'b10;
  localparam logic [1:0] MEM_UART_STAT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    RAM_WR,
    UART_RD,
    UART_WR,
    DONE
  } memState_t;

  // True when this read/write pair needs a multi-cycle bus access.
  // Any read (including a status read) suppresses the write.
  function automatic logic startsAccess(input logic [1:0] rdOp, input logic [1:0] wrOp);
    logic rdBus;
    logic wrBus;
    rdBus = (rdOp == MEM_RAM) || (rdOp == MEM_UART);
    wrBus = (rdOp == MEM_NONE) && ((wrOp == MEM_RAM) || (wrOp == MEM_UART));
    return rdBus || wrBus;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// External memory/UART bus seen by the MEM stage. The SRAM data bus is
// split into out/in halves; the tristate lives at the chip top.
interface mem_stage_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDataOut;
  logic [DATA_W-1:0] ramDataIn;
  logic              ramDataOE;
  logic              ramCE_n;
  logic              ramOE_n;
  logic              ramWE_n;
  logic              uartRdn;
  logic              uartWrn;
  logic              uartDataReady;
  logic              uartTbre;
  logic              uartTsre;

  modport master (
    output ramAddr, ramDataOut, ramDataOE, ramCE_n, ramOE_n, ramWE_n, uartRdn, uartWrn,
    input  ramDataIn, uartDataReady, uartTbre, uartTsre
  );

  modport slave (
    input  ramAddr, ramDataOut, ramDataOE, ramCE_n, ramOE_n, ramWE_n, uartRdn, uartWrn,
    output ramDataIn, uartDataReady, uartTbre, uartTsre
  );

endinterface

// File: rtl/mem_access_fsm.sv
// Bus sequencer for loads/stores to the async SRAM and the UART.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no access in flight; decides what the EX/MEM op needs
//   RAM_RD  | CE_n/OE_n low for RAM_WAIT cycles, data captured at the end
//   RAM_WR  | CE_n low RAM_WAIT cycles, WE_n released one cycle early
//   UART_RD | wait for dataReady, then one-cycle rdn pulse and capture
//   UART_WR | wait for tbre&tsre, then one-cycle wrn pulse
//   DONE    | result ready; stall released, MEM/WB loads on next edge
//
// All strobes come straight from flops so they never glitch.
module mem_access_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        memReadIn,
  input  logic [1:0]        memWriteIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] dataIn,
  mem_stage_if.master       bus,
  output memState_t         state,
  output logic [DATA_W-1:0] readData
);

  localparam logic [3:0] WAIT_LOAD = 4'(RAM_WAIT - 1);

  memState_t  nextState;
  logic [3:0] waitCnt;
  logic       txEmpty;

  assign txEmpty = bus.uartTbre & bus.uartTsre;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state decode; a read of any kind takes precedence over a write.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (memReadIn == MEM_RAM)                                nextState = RAM_RD;
        else if (memReadIn == MEM_UART)                          nextState = UART_RD;
        else if (memReadIn == MEM_NONE && memWriteIn == MEM_RAM)  nextState = RAM_WR;
        else if (memReadIn == MEM_NONE && memWriteIn == MEM_UART) nextState = UART_WR;
      end
      RAM_RD, RAM_WR: if (waitCnt == 4'd0) nextState = DONE;
      UART_RD:        if (!bus.uartRdn)    nextState = DONE;
      UART_WR:        if (!bus.uartWrn)    nextState = DONE;
      DONE:           nextState = IDLE;
      default:        nextState = IDLE;
    endcase
  end

  // Registered strobes, wait down-counter, held address/data and read capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      waitCnt        <= '0;
      readData       <= '0;
      bus.ramAddr    <= '0;
      bus.ramDataOut <= '0;
      bus.ramDataOE  <= 1'b0;
      bus.ramCE_n    <= 1'b1;
      bus.ramOE_n    <= 1'b1;
      bus.ramWE_n    <= 1'b1;
      bus.uartRdn    <= 1'b1;
      bus.uartWrn    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (nextState != IDLE) readData <= '0;
          case (nextState)
            RAM_RD: begin
              bus.ramCE_n <= 1'b0;
              bus.ramOE_n <= 1'b0;
              bus.ramAddr <= ALUResultIn;
              waitCnt     <= WAIT_LOAD;
            end
            RAM_WR: begin
              bus.ramCE_n    <= 1'b0;
              bus.ramWE_n    <= 1'b0;
              bus.ramDataOE  <= 1'b1;
              bus.ramAddr    <= ALUResultIn;
              bus.ramDataOut <= dataIn;
              waitCnt        <= WAIT_LOAD;
            end
            UART_RD: bus.uartRdn <= ~bus.uartDataReady;
            UART_WR: begin
              bus.uartWrn    <= ~txEmpty;
              bus.ramDataOE  <= 1'b1;
              bus.ramDataOut <= dataIn;
            end
            default: ;
          endcase
        end
        RAM_RD: begin
          if (waitCnt == 4'd0) begin
            readData    <= bus.ramDataIn;
            bus.ramCE_n <= 1'b1;
            bus.ramOE_n <= 1'b1;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RAM_WR: begin
          if (waitCnt == 4'd0) begin
            bus.ramCE_n   <= 1'b1;
            bus.ramWE_n   <= 1'b1;
            bus.ramDataOE <= 1'b0;
          end else begin
            waitCnt <= waitCnt - 4'd1;
            // Lift WE_n one cycle before CE_n so address/data outlive it.
            if (waitCnt == 4'd1) bus.ramWE_n <= 1'b1;
          end
        end
        UART_RD: begin
          if (!bus.uartRdn) begin
            readData    <= {8'h00, bus.ramDataIn[7:0]};
            bus.uartRdn <= 1'b1;
          end else begin
            bus.uartRdn <= ~bus.uartDataReady;
          end
        end
        UART_WR: begin
          if (!bus.uartWrn) begin
            bus.uartWrn   <= 1'b1;
            bus.ramDataOE <= 1'b0;
          end else begin
            bus.uartWrn <= ~txEmpty;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: bus access via mem_access_fsm, branch resolution,
// stall generation and the MEM/WB pipeline register.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          writeSpecRegIn,
  input  logic                memtoRegIn,
  input  logic                regWriteIn,
  input  logic [1:0]          memReadIn,
  input  logic [1:0]          memWriteIn,
  input  logic                branchIn,
  input  logic                zerobitIn,
  input  logic [DATA_W-1:0]   PCIn,
  input  logic [DATA_W-1:0]   ALUResultIn,
  input  logic [DATA_W-1:0]   dataIn,
  input  logic [REG_ID_W-1:0] registerToWriteIdIn,
  mem_stage_if.master         bus,
  output logic                stall,
  output logic                branchTaken,
  output logic [DATA_W-1:0]   branchTarget,
  output logic [1:0]          writeSpecRegOut,
  output logic                memtoRegOut,
  output logic                regWriteOut,
  output logic [DATA_W-1:0]   memDataOut,
  output logic [DATA_W-1:0]   ALUResultOut,
  output logic [REG_ID_W-1:0] registerToWriteIdOut
);

  memState_t         state;
  logic [DATA_W-1:0] readData;
  logic [DATA_W-1:0] memResult;

  mem_access_fsm #(.RAM_WAIT(RAM_WAIT)) uAccess (
    .CLK         (CLK),
    .RST         (RST),
    .memReadIn   (memReadIn),
    .memWriteIn  (memWriteIn),
    .ALUResultIn (ALUResultIn),
    .dataIn      (dataIn),
    .bus         (bus),
    .state       (state),
    .readData    (readData)
  );

  // Branches only resolve when no access is in flight, so a held instruction can't re-fire.
  assign branchTaken  = branchIn & zerobitIn & (state == IDLE);
  assign branchTarget = PCIn;

  // Stall while an access is starting or running; reset must never leave the pipe frozen.
  always_comb begin
    stall = 1'b0;
    if (!RST) begin
      if (state == IDLE)      stall = startsAccess(memReadIn, memWriteIn);
      else if (state != DONE) stall = 1'b1;
    end
  end

  // Data offered to MEM/WB: a finished bus read, or the UART status word which needs no bus cycle.
  always_comb begin
    memResult = '0;
    if (state == DONE)
      memResult = readData;
    else if (state == IDLE && memReadIn == MEM_UART_STAT)
      memResult = {14'b0, bus.uartDataReady, bus.uartTbre & bus.uartTsre};
  end

  // MEM/WB register: load when not stalled, otherwise insert a bubble by clearing write controls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      writeSpecRegOut      <= '0;
      memtoRegOut          <= 1'b0;
      regWriteOut          <= 1'b0;
      memDataOut           <= '0;
      ALUResultOut         <= '0;
      registerToWriteIdOut <= '0;
    end else if (!stall) begin
      writeSpecRegOut      <= writeSpecRegIn;
      memtoRegOut          <= memtoRegIn;
      regWriteOut          <= regWriteIn;
      memDataOut           <= memResult;
      ALUResultOut         <= ALUResultIn;
      registerToWriteIdOut <= registerToWriteIdIn;
    end else begin
      writeSpecRegOut <= '0;
      memtoRegOut     <= 1'b0;
      regWriteOut     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios then random instructions,
// each checked against a transaction-level expectation of latency,
// strobe pulse widths and the resulting MEM/WB contents.
module tb_mem_stage;
  import cpu_pkg::*;

  localparam int RAM_WAIT = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  writeSpecRegIn;
  logic        memtoRegIn;
  logic        regWriteIn;
  logic [1:0]  memReadIn;
  logic [1:0]  memWriteIn;
  logic        branchIn;
  logic        zerobitIn;
  logic [15:0] PCIn;
  logic [15:0] ALUResultIn;
  logic [15:0] dataIn;
  logic [2:0]  registerToWriteIdIn;
  logic        stall;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [1:0]  writeSpecRegOut;
  logic        memtoRegOut;
  logic        regWriteOut;
  logic [15:0] memDataOut;
  logic [15:0] ALUResultOut;
  logic [2:0]  registerToWriteIdOut;

  int nCmp = 0;
  int nBad = 0;

  mem_stage_if bus();

  mem_stage #(.RAM_WAIT(RAM_WAIT)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .writeSpecRegIn       (writeSpecRegIn),
    .memtoRegIn           (memtoRegIn),
    .regWriteIn           (regWriteIn),
    .memReadIn            (memReadIn),
    .memWriteIn           (memWriteIn),
    .branchIn             (branchIn),
    .zerobitIn            (zerobitIn),
    .PCIn                 (PCIn),
    .ALUResultIn          (ALUResultIn),
    .dataIn               (dataIn),
    .registerToWriteIdIn  (registerToWriteIdIn),
    .bus                  (bus),
    .stall                (stall),
    .branchTaken          (branchTaken),
    .branchTarget         (branchTarget),
    .writeSpecRegOut      (writeSpecRegOut),
    .memtoRegOut          (memtoRegOut),
    .regWriteOut          (regWriteOut),
    .memDataOut           (memDataOut),
    .ALUResultOut         (ALUResultOut),
    .registerToWriteIdOut (registerToWriteIdOut)
  );

  always #5 CLK = ~CLK;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 ALU, 1 RAM read, 2 RAM write, 3 UART read, 4 UART write, 5 UART status
  // delay: cycles until the UART becomes ready (kinds 3/4)
  // for kind 5, wdata[2:0] = {dataReady, tbre, tsre}
  task automatic runInstr(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] rdata, input int delay, input logic regWr);
    int cyc, stallCnt, ceLow, oeLow, weLow, rdnLow, wrnLow, holdErr, bubbleErr;
    int expStall, expCe, expOe, expWe;
    logic [15:0] expData;
    logic [1:0]  wsr;
    logic        m2r, lowBit;
    logic [2:0]  rid;
    logic [15:0] pc;
    logic        br, zb;

    wsr = 2'($urandom); m2r = 1'($urandom); rid = 3'($urandom);
    pc = 16'($urandom); br = 1'($urandom); zb = 1'($urandom);
    writeSpecRegIn = wsr; memtoRegIn = m2r; regWriteIn = regWr;
    registerToWriteIdIn = rid; PCIn = pc; branchIn = br; zerobitIn = zb;
    ALUResultIn = addr; dataIn = wdata; bus.ramDataIn = rdata;
    bus.uartDataReady = 1'($urandom); bus.uartTbre = 1'($urandom); bus.uartTsre = 1'($urandom);

    expStall = 0; expCe = 0; expOe = 0; expWe = 0; expData = 16'h0;
    case (kind)
      1: begin
        memReadIn = MEM_RAM; memWriteIn = 2'($urandom);
        expStall = RAM_WAIT + 1; expCe = RAM_WAIT; expOe = RAM_WAIT; expData = rdata;
      end
      2: begin
        memReadIn = MEM_NONE; memWriteIn = MEM_RAM;
        expStall = RAM_WAIT + 1; expCe = RAM_WAIT; expWe = (RAM_WAIT > 1) ? RAM_WAIT - 1 : 1;
      end
      3: begin
        memReadIn = MEM_UART; memWriteIn = 2'($urandom);
        bus.uartDataReady = (delay == 0);
        expStall = delay + 2; expData = {8'h00, rdata[7:0]};
      end
      4: begin
        memReadIn = MEM_NONE; memWriteIn = MEM_UART;
        lowBit = 1'($urandom);
        bus.uartTbre = (delay == 0) ? 1'b1 : lowBit;
        bus.uartTsre = (delay == 0) ? 1'b1 : ~lowBit;
        expStall = delay + 2;
      end
      5: begin
        memReadIn = MEM_UART_STAT; memWriteIn = 2'($urandom);
        bus.uartDataReady = wdata[2]; bus.uartTbre = wdata[1]; bus.uartTsre = wdata[0];
        expData = {14'b0, wdata[2], wdata[1] & wdata[0]};
      end
      default: begin
        memReadIn = MEM_NONE; memWriteIn = ($urandom % 2) ? MEM_UART_STAT : MEM_NONE;
      end
    endcase

    #1;
    checkEq("branchTaken", {31'b0, branchTaken}, {31'b0, br & zb});
    checkEq("branchTarget", {16'b0, branchTarget}, {16'b0, pc});

    cyc = 0; stallCnt = 0; ceLow = 0; oeLow = 0; weLow = 0; rdnLow = 0; wrnLow = 0;
    holdErr = 0; bubbleErr = 0;
    forever begin
      if (stall) stallCnt++;
      if (!bus.ramCE_n) begin
        ceLow++;
        if (bus.ramAddr !== addr) holdErr++;
        if (kind == 2 && (bus.ramDataOut !== wdata || bus.ramDataOE !== 1'b1)) holdErr++;
      end
      if (!bus.ramOE_n) oeLow++;
      if (!bus.ramWE_n) begin
        weLow++;
        if (bus.ramCE_n) holdErr++;
      end
      if (!bus.uartRdn) rdnLow++;
      if (!bus.uartWrn) begin
        wrnLow++;
        if (bus.ramDataOut[7:0] !== wdata[7:0] || bus.ramDataOE !== 1'b1) holdErr++;
      end
      if (cyc > 0 && stall && regWriteOut) bubbleErr++;
      if (!stall || cyc >= 100) break;
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      if (cyc == delay) begin
        if (kind == 3) bus.uartDataReady = 1'b1;
        if (kind == 4) begin bus.uartTbre = 1'b1; bus.uartTsre = 1'b1; end
      end
      #1;
    end

    checkEq("noTimeout", {31'b0, cyc < 100}, 32'd1);
    checkEq("stallCycles", stallCnt, expStall);
    checkEq("ceLowCycles", ceLow, expCe);
    checkEq("oeLowCycles", oeLow, expOe);
    checkEq("weLowCycles", weLow, expWe);
    checkEq("rdnLowCycles", rdnLow, (kind == 3) ? 1 : 0);
    checkEq("wrnLowCycles", wrnLow, (kind == 4) ? 1 : 0);
    checkEq("busHold", holdErr, 0);
    checkEq("bubble", bubbleErr, 0);

    @(posedge CLK);
    @(negedge CLK);
    checkEq("regWriteOut", {31'b0, regWriteOut}, {31'b0, regWr});
    checkEq("memtoRegOut", {31'b0, memtoRegOut}, {31'b0, m2r});
    checkEq("writeSpecRegOut", {30'b0, writeSpecRegOut}, {30'b0, wsr});
    checkEq("ALUResultOut", {16'b0, ALUResultOut}, {16'b0, addr});
    checkEq("regIdOut", {29'b0, registerToWriteIdOut}, {29'b0, rid});
    checkEq("memDataOut", {16'b0, memDataOut}, {16'b0, expData});
  endtask

  initial begin
    RST = 1'b1;
    writeSpecRegIn = 0; memtoRegIn = 0; regWriteIn = 0; memReadIn = 0; memWriteIn = 0;
    branchIn = 0; zerobitIn = 0; PCIn = 0; ALUResultIn = 0; dataIn = 0; registerToWriteIdIn = 0;
    bus.ramDataIn = 0; bus.uartDataReady = 0; bus.uartTbre = 0; bus.uartTsre = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkEq("rstStrobes", {25'b0, bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.uartRdn,
                           bus.uartWrn, bus.ramDataOE, stall}, 32'h7C);
    checkEq("rstRamBus", {bus.ramAddr, bus.ramDataOut}, 32'h0);
    checkEq("rstMemWb", {writeSpecRegOut, memtoRegOut, regWriteOut, registerToWriteIdOut,
                         memDataOut[8:0]}, 32'h0);
    checkEq("rstMemWbData", {memDataOut, ALUResultOut}, 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    runInstr(0, 16'h1234, 16'h0000, 16'h0000, 0, 1'b1);
    runInstr(1, 16'h4000, 16'h0000, 16'hBEEF, 0, 1'b1);
    runInstr(2, 16'h8000, 16'hA5A5, 16'h0000, 0, 1'b0);
    runInstr(3, 16'h0010, 16'h0000, 16'h3C7A, 5, 1'b1);
    runInstr(4, 16'h0011, 16'h005A, 16'h0000, 3, 1'b0);
    runInstr(5, 16'h0012, 16'h0006, 16'h0000, 0, 1'b1);

    // Reset in the middle of a RAM read.
    memReadIn = MEM_RAM; memWriteIn = MEM_NONE; ALUResultIn = 16'h4000; regWriteIn = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkEq("preRstOe", {31'b0, bus.ramOE_n}, 32'd0);
    RST = 1'b1;
    #1;
    checkEq("midRstStrobes", {25'b0, bus.ramCE_n, bus.ramOE_n, bus.ramWE_n, bus.uartRdn,
                              bus.uartWrn, bus.ramDataOE, stall}, 32'h7C);
    checkEq("midRstRegWrite", {31'b0, regWriteOut}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    runInstr(1, 16'h4000, 16'h0000, 16'hC0DE, 0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      runInstr($urandom_range(0, 5), 16'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 6), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
